reg_read_stage: RTL and testbench
=================================

REG_READ_STAGE -- requirements
Module: RegReadStage

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state on rising edge; rst  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have upstream ports:
- inValid  in  1  decoded op present.
- inReady  out  1  op accepted this cycle.
- inPc, inInsn  in  32  debug/trap context.
- inRs1, inRs2, inRs3, inRd  in  5  register addresses.
- inSrcFp  in  3  per-source select, bit k=1 means source k+1 reads the FP file.
- inSrcUse  in  3  per-source used flag.
- inIntRdWe, inFpRdWe  in  1  destination write enables.
REQ-003 SHALL have register-file read ports:
- intReadAddr1/2  out  5, with intReadValue1/2  in  32.
- fpReadAddr1/2/3  out  5, with fpReadValue1/2/3  in  32.
- Reads are combinational in the same cycle.
REQ-004 SHALL have writeback snoop ports:
- wbIntWe, wbFpWe  in  1.
- wbAddr  in  5.
- wbIntValue, wbFpValue  in  32.
- These carry the same-cycle register-file write from the write stage.
REQ-005 SHALL have control ports: flush  in  1  kill the stage and all in-flight writers; nextStall  in  1  downstream cannot accept.
REQ-006 SHALL have downstream ports:
- outValid  out  1.
- outPc, outInsn  out  32.
- outRd  out  5.
- outIntRdWe, outFpRdWe  out  1.
- outSrc1, outSrc2, outSrc3  out  32.

Function
REQ-007 SHALL use source k+1 with int address inRs1/inRs2 (source 3 is FP-only) and FP address inRs1/inRs2/inRs3, selected by inSrcFp.
REQ-008 SHALL keep a 32-bit int busy vector and a 32-bit FP busy vector (scoreboard); int bit 0 SHALL be constant 0.
REQ-009 SHALL treat a used source as hazardous when its busy bit is set, unless a same-cycle writeback to that file and address clears it.
REQ-010 SHALL raise a WAW hazard when the destination busy bit is set and is not being cleared this cycle.
REQ-011 SHALL drive inReady = !flush && !hazard && !(outValid && nextStall); inReady SHALL NOT depend on inValid.
REQ-012 SHALL capture on accept (inValid && inReady): outValid=1, context fields, and source values into the output register; latency is exactly 1 cycle.
REQ-013 SHALL bypass per source: when the matching wb*We is set and wbAddr equals the source address, the captured value SHALL be wbIntValue/wbFpValue instead of the file value.
REQ-014 SHALL capture int source value 0 for address 0 regardless of file or bypass; unused sources SHALL capture 0.
REQ-015 SHALL on accept set busy[inRd] in the int vector if inIntRdWe && inRd!=0, and in the FP vector if inFpRdWe.
REQ-016 SHALL clear busy[wbAddr] in the matching vector on wbIntWe/wbFpWe; a set and clear of the same bit in the same cycle SHALL leave it set.
REQ-017 SHALL hold all outputs stable while outValid && nextStall.
REQ-018 SHALL clear outValid when the output is consumed (outValid && !nextStall) and nothing is accepted.
REQ-019 SHALL handle flush as follows:
- Flush has priority over accept and capture.
- On the next edge, outValid=0 and both busy vectors clear.
- Writebacks during the flush cycle are ignored for scoreboard purposes.
- Flush is how trapped, non-committing instructions release their destinations.
REQ-020 SHALL never emit X on outputs while outValid=0; held data SHALL be the last captured value.

Reset
REQ-021 SHALL on rst=0 asynchronously clear outValid, both busy vectors, and all out data registers to 0.
REQ-022 SHALL drive inReady=0 while rst is asserted, and SHALL accept on the first edge after deassertion if inValid.

Verification
REQ-023 SHALL cover RAW stall:
- Issue addi x5 (int rd, accepted), then add x6,x5,x1.
- Expect inReady=0 until wbIntWe, wbAddr=5, wbIntValue=0x11.
- In that cycle expect accept, and outSrc1=0x11 on the next cycle.
REQ-024 SHALL cover x0 handling: issue an op with rd=x0, then a reader of x0 while the int file returns 0xDEAD for address 0; expect no stall and outSrc1=0.
REQ-025 SHALL cover back-pressure: hold nextStall=1 for 3 cycles with outValid=1; expect outputs unchanged, inReady=0, and no busy bits changed.
REQ-026 SHALL cover flush: set FP busy f3 and int busy x7, assert flush together with inValid; expect no capture, outValid=0 next cycle, and a following reader of f3 accepted immediately.
REQ-027 SHALL cover same-edge set and clear: busy x4 is cleared by writeback in the same cycle a new op with rd=x4 is accepted; expect no stall and busy x4 remaining 1.
REQ-028 SHALL cover reset mid-stall: assert rst while stalled on a hazard; expect outValid=0 and busy vectors 0 immediately, and the pending op accepted on the first edge after release.

Source files
------------

// File: rtl/reg_read_stage.sv
// Register-read stage: scoreboarded operand fetch with writeback bypass,
// one-entry output register, back-pressure and flush handling.
module reg_read_stage #(
    localparam int unsigned XLEN = 32,
    localparam int unsigned AW   = 5,
    localparam int unsigned NSRC = 3
) (
    input  logic            clk,
    input  logic            rst,
    // upstream
    input  logic            inValid,
    output logic            inReady,
    input  logic [XLEN-1:0] inPc,
    input  logic [XLEN-1:0] inInsn,
    input  logic [AW-1:0]   inRs1,
    input  logic [AW-1:0]   inRs2,
    input  logic [AW-1:0]   inRs3,
    input  logic [AW-1:0]   inRd,
    input  logic [NSRC-1:0] inSrcFp,
    input  logic [NSRC-1:0] inSrcUse,
    input  logic            inIntRdWe,
    input  logic            inFpRdWe,
    // register files
    output logic [AW-1:0]   intReadAddr1,
    output logic [AW-1:0]   intReadAddr2,
    input  logic [XLEN-1:0] intReadValue1,
    input  logic [XLEN-1:0] intReadValue2,
    output logic [AW-1:0]   fpReadAddr1,
    output logic [AW-1:0]   fpReadAddr2,
    output logic [AW-1:0]   fpReadAddr3,
    input  logic [XLEN-1:0] fpReadValue1,
    input  logic [XLEN-1:0] fpReadValue2,
    input  logic [XLEN-1:0] fpReadValue3,
    // writeback snoop
    input  logic            wbIntWe,
    input  logic            wbFpWe,
    input  logic [AW-1:0]   wbAddr,
    input  logic [XLEN-1:0] wbIntValue,
    input  logic [XLEN-1:0] wbFpValue,
    // control
    input  logic            flush,
    input  logic            nextStall,
    // downstream
    output logic            outValid,
    output logic [XLEN-1:0] outPc,
    output logic [XLEN-1:0] outInsn,
    output logic [AW-1:0]   outRd,
    output logic            outIntRdWe,
    output logic            outFpRdWe,
    output logic [XLEN-1:0] outSrc1,
    output logic [XLEN-1:0] outSrc2,
    output logic [XLEN-1:0] outSrc3
);

    logic [XLEN-1:0] r_int_busy, r_fp_busy;
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_pc, r_out_insn, r_src1, r_src2, r_src3;
    logic [AW-1:0]   r_out_rd;
    logic            r_out_int_we, r_out_fp_we;

    logic [XLEN-1:0] w_int_clr, w_fp_clr, w_int_pend, w_fp_pend;
    logic [XLEN-1:0] w_int_set, w_fp_set, w_int_busy_nxt, w_fp_busy_nxt;
    logic [NSRC-1:0] w_use;
    logic            w_raw, w_waw, w_hazard, w_accept;
    logic [XLEN-1:0] w_src1, w_src2, w_src3;

    function automatic logic [XLEN-1:0] int_val(input logic [AW-1:0] a, input logic [XLEN-1:0] rf,
                                                input logic we, input logic [AW-1:0] wa,
                                                input logic [XLEN-1:0] wv);
        if (a == AW'(0))         return '0;
        else if (we && wa == a)  return wv;
        else                     return rf;
    endfunction

    function automatic logic [XLEN-1:0] fp_val(input logic [AW-1:0] a, input logic [XLEN-1:0] rf,
                                               input logic we, input logic [AW-1:0] wa,
                                               input logic [XLEN-1:0] wv);
        return (we && wa == a) ? wv : rf;
    endfunction

    assign intReadAddr1 = inRs1;
    assign intReadAddr2 = inRs2;
    assign fpReadAddr1  = inRs1;
    assign fpReadAddr2  = inRs2;
    assign fpReadAddr3  = inRs3;

    // Source 3 only exists in the FP file.
    assign w_use = {inSrcUse[2] & inSrcFp[2], inSrcUse[1:0]};

    // A busy bit being retired by this cycle's writeback is no longer a hazard.
    assign w_int_clr  = wbIntWe ? (XLEN'(1) << wbAddr) : '0;
    assign w_fp_clr   = wbFpWe  ? (XLEN'(1) << wbAddr) : '0;
    assign w_int_pend = r_int_busy & ~w_int_clr;
    assign w_fp_pend  = r_fp_busy  & ~w_fp_clr;

    always_comb begin
        w_raw = 1'b0;
        w_waw = 1'b0;
        if (w_use[0]) w_raw = w_raw | (inSrcFp[0] ? w_fp_pend[inRs1] : w_int_pend[inRs1]);
        if (w_use[1]) w_raw = w_raw | (inSrcFp[1] ? w_fp_pend[inRs2] : w_int_pend[inRs2]);
        if (w_use[2]) w_raw = w_raw | w_fp_pend[inRs3];
        if (inIntRdWe) w_waw = w_waw | w_int_pend[inRd];
        if (inFpRdWe)  w_waw = w_waw | w_fp_pend[inRd];
    end

    assign w_hazard = w_raw | w_waw;
    assign inReady  = rst & ~flush & ~w_hazard & ~(r_out_valid & nextStall);
    assign w_accept = inValid & inReady;

    always_comb begin
        w_src1 = '0;
        w_src2 = '0;
        w_src3 = '0;
        if (w_use[0])
            w_src1 = inSrcFp[0] ? fp_val(inRs1, fpReadValue1, wbFpWe, wbAddr, wbFpValue)
                                : int_val(inRs1, intReadValue1, wbIntWe, wbAddr, wbIntValue);
        if (w_use[1])
            w_src2 = inSrcFp[1] ? fp_val(inRs2, fpReadValue2, wbFpWe, wbAddr, wbFpValue)
                                : int_val(inRs2, intReadValue2, wbIntWe, wbAddr, wbIntValue);
        if (w_use[2])
            w_src3 = fp_val(inRs3, fpReadValue3, wbFpWe, wbAddr, wbFpValue);
    end

    // Set wins over a same-cycle clear; int x0 can never be busy.
    assign w_int_set      = (w_accept && inIntRdWe && inRd != AW'(0)) ? (XLEN'(1) << inRd) : '0;
    assign w_fp_set       = (w_accept && inFpRdWe) ? (XLEN'(1) << inRd) : '0;
    assign w_int_busy_nxt = (w_int_pend | w_int_set) & ~XLEN'(1);
    assign w_fp_busy_nxt  = w_fp_pend | w_fp_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_int_busy   <= '0;
            r_fp_busy    <= '0;
            r_out_valid  <= 1'b0;
            r_out_pc     <= '0;
            r_out_insn   <= '0;
            r_out_rd     <= '0;
            r_out_int_we <= 1'b0;
            r_out_fp_we  <= 1'b0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_src3       <= '0;
        end else if (flush) begin
            r_int_busy  <= '0;
            r_fp_busy   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_int_busy <= w_int_busy_nxt;
            r_fp_busy  <= w_fp_busy_nxt;
            if (w_accept) begin
                r_out_valid  <= 1'b1;
                r_out_pc     <= inPc;
                r_out_insn   <= inInsn;
                r_out_rd     <= inRd;
                r_out_int_we <= inIntRdWe;
                r_out_fp_we  <= inFpRdWe;
                r_src1       <= w_src1;
                r_src2       <= w_src2;
                r_src3       <= w_src3;
            end else if (r_out_valid && !nextStall) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign outValid   = r_out_valid;
    assign outPc      = r_out_pc;
    assign outInsn    = r_out_insn;
    assign outRd      = r_out_rd;
    assign outIntRdWe = r_out_int_we;
    assign outFpRdWe  = r_out_fp_we;
    assign outSrc1    = r_src1;
    assign outSrc2    = r_src2;
    assign outSrc3    = r_src3;

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage: RAW stall, x0, back-pressure, flush,
// same-edge set/clear, bypass and reset during a stall.
module tb_reg_read_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid, inReady;
    logic [31:0] inPc, inInsn;
    logic [4:0]  inRs1, inRs2, inRs3, inRd;
    logic [2:0]  inSrcFp, inSrcUse;
    logic        inIntRdWe, inFpRdWe;
    logic [4:0]  intReadAddr1, intReadAddr2, fpReadAddr1, fpReadAddr2, fpReadAddr3;
    logic [31:0] intReadValue1, intReadValue2, fpReadValue1, fpReadValue2, fpReadValue3;
    logic        wbIntWe, wbFpWe;
    logic [4:0]  wbAddr;
    logic [31:0] wbIntValue, wbFpValue;
    logic        flush, nextStall;
    logic        outValid, outIntRdWe, outFpRdWe;
    logic [31:0] outPc, outInsn, outSrc1, outSrc2, outSrc3;
    logic [4:0]  outRd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_read_stage dut (
        .clk(clk), .rst(rst),
        .inValid(inValid), .inReady(inReady), .inPc(inPc), .inInsn(inInsn),
        .inRs1(inRs1), .inRs2(inRs2), .inRs3(inRs3), .inRd(inRd),
        .inSrcFp(inSrcFp), .inSrcUse(inSrcUse), .inIntRdWe(inIntRdWe), .inFpRdWe(inFpRdWe),
        .intReadAddr1(intReadAddr1), .intReadAddr2(intReadAddr2),
        .intReadValue1(intReadValue1), .intReadValue2(intReadValue2),
        .fpReadAddr1(fpReadAddr1), .fpReadAddr2(fpReadAddr2), .fpReadAddr3(fpReadAddr3),
        .fpReadValue1(fpReadValue1), .fpReadValue2(fpReadValue2), .fpReadValue3(fpReadValue3),
        .wbIntWe(wbIntWe), .wbFpWe(wbFpWe), .wbAddr(wbAddr),
        .wbIntValue(wbIntValue), .wbFpValue(wbFpValue),
        .flush(flush), .nextStall(nextStall),
        .outValid(outValid), .outPc(outPc), .outInsn(outInsn), .outRd(outRd),
        .outIntRdWe(outIntRdWe), .outFpRdWe(outFpRdWe),
        .outSrc1(outSrc1), .outSrc2(outSrc2), .outSrc3(outSrc3)
    );

    // Register-file models; int address 0 deliberately returns garbage.
    function automatic logic [31:0] int_rf(input logic [4:0] a);
        return (a == 5'd0) ? 32'hDEAD : (32'h1000_0000 | 32'(a));
    endfunction
    function automatic logic [31:0] fp_rf(input logic [4:0] a);
        return 32'h2000_0000 | 32'(a);
    endfunction

    assign intReadValue1 = int_rf(intReadAddr1);
    assign intReadValue2 = int_rf(intReadAddr2);
    assign fpReadValue1  = fp_rf(fpReadAddr1);
    assign fpReadValue2  = fp_rf(fpReadAddr2);
    assign fpReadValue3  = fp_rf(fpReadAddr3);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        inValid = 1'b0; inPc = '0; inInsn = '0;
        inRs1 = '0; inRs2 = '0; inRs3 = '0; inRd = '0;
        inSrcFp = '0; inSrcUse = '0; inIntRdWe = 1'b0; inFpRdWe = 1'b0;
        wbIntWe = 1'b0; wbFpWe = 1'b0; wbAddr = '0; wbIntValue = '0; wbFpValue = '0;
        flush = 1'b0; nextStall = 1'b0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rs3, input logic [4:0] rd, input logic [2:0] fp,
                         input logic [2:0] use_, input logic iwe, input logic fwe);
        inValid = 1'b1; inPc = pc; inInsn = pc + 32'h13;
        inRs1 = rs1; inRs2 = rs2; inRs3 = rs3; inRd = rd;
        inSrcFp = fp; inSrcUse = use_; inIntRdWe = iwe; inFpRdWe = fwe;
    endtask

    task automatic wb_clear();
        wbIntWe = 1'b0; wbFpWe = 1'b0; wbAddr = '0; wbIntValue = '0; wbFpValue = '0;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        #2;
        chk("reset_valid", 32'(outValid), 32'd0);
        chk("reset_ready", 32'(inReady), 32'd0);
        chk("reset_src1", outSrc1, 32'd0);
        chk("reset_busy", dut.r_int_busy | dut.r_fp_busy, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // addi x5, x1
        issue(32'h100, 5'd1, 5'd0, 5'd0, 5'd5, 3'b000, 3'b001, 1'b1, 1'b0);
        settle();
        chk("addi_ready", 32'(inReady), 32'd1);
        tick();
        chk("addi_valid", 32'(outValid), 32'd1);
        chk("addi_pc", outPc, 32'h100);
        chk("addi_insn", outInsn, 32'h113);
        chk("addi_src1", outSrc1, 32'h1000_0001);
        chk("addi_src2_unused", outSrc2, 32'd0);
        chk("addi_rd", 32'(outRd), 32'd5);
        chk("addi_busy", dut.r_int_busy, 32'h0000_0020);

        // add x6, x5, x1 stalls on x5
        issue(32'h104, 5'd5, 5'd1, 5'd0, 5'd6, 3'b000, 3'b011, 1'b1, 1'b0);
        settle();
        chk("raw_stall0", 32'(inReady), 32'd0);
        tick();
        chk("raw_drain_valid", 32'(outValid), 32'd0);
        chk("raw_hold_pc", outPc, 32'h100);
        settle();
        chk("raw_stall1", 32'(inReady), 32'd0);
        wbIntWe = 1'b1; wbAddr = 5'd5; wbIntValue = 32'h11;
        settle();
        chk("raw_wb_ready", 32'(inReady), 32'd1);
        tick();
        wb_clear();
        chk("raw_valid", 32'(outValid), 32'd1);
        chk("raw_src1_bypass", outSrc1, 32'h11);
        chk("raw_src2", outSrc2, 32'h1000_0001);
        chk("raw_busy", dut.r_int_busy, 32'h0000_0040);

        // rd = x0 is never marked busy; reading x0 yields 0
        issue(32'h200, 5'd2, 5'd0, 5'd0, 5'd0, 3'b000, 3'b001, 1'b1, 1'b0);
        settle();
        chk("x0w_ready", 32'(inReady), 32'd1);
        tick();
        chk("x0w_busy", dut.r_int_busy, 32'h0000_0040);
        issue(32'h204, 5'd0, 5'd0, 5'd0, 5'd7, 3'b000, 3'b001, 1'b1, 1'b0);
        settle();
        chk("x0r_ready", 32'(inReady), 32'd1);
        tick();
        chk("x0r_src1", outSrc1, 32'd0);
        chk("x0r_busy", dut.r_int_busy, 32'h0000_00C0);

        // back-pressure for three cycles
        issue(32'h300, 5'd3, 5'd0, 5'd0, 5'd8, 3'b000, 3'b001, 1'b1, 1'b0);
        nextStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_ready", 32'(inReady), 32'd0);
            tick();
            chk("bp_valid", 32'(outValid), 32'd1);
            chk("bp_pc", outPc, 32'h204);
            chk("bp_src1", outSrc1, 32'd0);
            chk("bp_busy", dut.r_int_busy, 32'h0000_00C0);
        end
        nextStall = 1'b0;
        settle();
        chk("bp_release_ready", 32'(inReady), 32'd1);
        tick();
        chk("bp_release_pc", outPc, 32'h300);
        chk("bp_release_busy", dut.r_int_busy, 32'h0000_01C0);

        // set f3 busy, then flush with a valid op and a writeback present
        issue(32'h400, 5'd9, 5'd0, 5'd0, 5'd3, 3'b001, 3'b001, 1'b0, 1'b1);
        settle();
        chk("fp_ready", 32'(inReady), 32'd1);
        tick();
        chk("fp_src1", outSrc1, 32'h2000_0009);
        chk("fp_busy", dut.r_fp_busy, 32'h0000_0008);
        issue(32'h500, 5'd4, 5'd0, 5'd0, 5'd10, 3'b000, 3'b001, 1'b1, 1'b0);
        flush = 1'b1;
        wbIntWe = 1'b1; wbAddr = 5'd7; wbIntValue = 32'h77;
        settle();
        chk("flush_ready", 32'(inReady), 32'd0);
        tick();
        flush = 1'b0;
        wb_clear();
        chk("flush_valid", 32'(outValid), 32'd0);
        chk("flush_hold_pc", outPc, 32'h400);
        chk("flush_busy", dut.r_int_busy | dut.r_fp_busy, 32'd0);
        issue(32'h600, 5'd3, 5'd0, 5'd0, 5'd0, 3'b001, 3'b001, 1'b0, 1'b0);
        settle();
        chk("post_flush_ready", 32'(inReady), 32'd1);
        tick();
        chk("post_flush_valid", 32'(outValid), 32'd1);
        chk("post_flush_src1", outSrc1, 32'h2000_0003);

        // same-edge set and clear of x4
        issue(32'h700, 5'd0, 5'd0, 5'd0, 5'd4, 3'b000, 3'b000, 1'b1, 1'b0);
        tick();
        chk("x4_busy", dut.r_int_busy, 32'h0000_0010);
        issue(32'h704, 5'd0, 5'd0, 5'd0, 5'd4, 3'b000, 3'b000, 1'b1, 1'b0);
        wbIntWe = 1'b1; wbAddr = 5'd4; wbIntValue = 32'h44;
        settle();
        chk("waw_clear_ready", 32'(inReady), 32'd1);
        tick();
        wb_clear();
        chk("waw_pc", outPc, 32'h704);
        chk("waw_busy_kept", dut.r_int_busy, 32'h0000_0010);

        // FP bypass on source 2, plain FP read on source 3
        issue(32'h800, 5'd0, 5'd5, 5'd6, 5'd0, 3'b110, 3'b110, 1'b0, 1'b0);
        wbFpWe = 1'b1; wbAddr = 5'd5; wbFpValue = 32'h55;
        settle();
        chk("fpbyp_ready", 32'(inReady), 32'd1);
        tick();
        wb_clear();
        chk("fpbyp_src1", outSrc1, 32'd0);
        chk("fpbyp_src2", outSrc2, 32'h55);
        chk("fpbyp_src3", outSrc3, 32'h2000_0006);

        // reset while stalled on x4
        issue(32'h900, 5'd4, 5'd0, 5'd0, 5'd9, 3'b000, 3'b001, 1'b1, 1'b0);
        settle();
        chk("rst_stall_ready", 32'(inReady), 32'd0);
        rst = 1'b0;
        settle();
        chk("rst_mid_valid", 32'(outValid), 32'd0);
        chk("rst_mid_busy", dut.r_int_busy | dut.r_fp_busy, 32'd0);
        chk("rst_mid_src2", outSrc2, 32'd0);
        chk("rst_mid_ready", 32'(inReady), 32'd0);
        #2;
        rst = 1'b1;
        settle();
        chk("rst_rel_ready", 32'(inReady), 32'd1);
        tick();
        chk("rst_rel_valid", 32'(outValid), 32'd1);
        chk("rst_rel_pc", outPc, 32'h900);
        chk("rst_rel_src1", outSrc1, 32'h1000_0004);
        chk("rst_rel_busy", dut.r_int_busy, 32'h0000_0200);

        idle();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
